// File: rtl/sa_operand_serializer.sv
// Operand serializer for a bit-serial adder: captures two parallel operands and
// streams them LSB first after a one-cycle carry-clear, then pulses done.
module sa_operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             A,
    output logic             B,
    output logic             sa_clr,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    // One extra counter bit so WIDTH=32 counts to 31 without wrapping; WIDTH=1 gets one bit.
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state and shift-register LSBs.
    always_comb begin
        A         = 1'b0;
        B         = 1'b0;
        sa_clr    = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CLEAR: begin
                sa_clr = 1'b1;
            end
            S_SHIFT: begin
                A         = a_sh_q[0];
                B         = b_sh_q[0];
                bit_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sa_operand_serializer.sv
// Directed self-checking bench for sa_operand_serializer at WIDTH 4, 1 and 8;
// output vectors are {A, B, sa_clr, bit_valid, busy, done}.
module tb_sa_operand_serializer;

    logic clk;
    logic rst;

    logic       st4, st1, st8;
    logic [3:0] a4, b4;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic A4, B4, clr4, bv4, busy4, done4;
    logic A1, B1, clr1, bv1, busy1, done1;
    logic A8, B8, clr8, bv8, busy8, done8;

    logic [5:0] o4, o1, o8;
    assign o4 = {A4, B4, clr4, bv4, busy4, done4};
    assign o1 = {A1, B1, clr1, bv1, busy1, done1};
    assign o8 = {A8, B8, clr8, bv8, busy8, done8};

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] V_IDLE  = 6'b000000;
    localparam logic [5:0] V_CLEAR = 6'b001010;
    localparam logic [5:0] V_DONE  = 6'b000011;

    sa_operand_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .a_in(a4), .b_in(b4),
        .A(A4), .B(B4), .sa_clr(clr4), .bit_valid(bv4), .busy(busy4), .done(done4)
    );

    sa_operand_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .a_in(a1), .b_in(b1),
        .A(A1), .B(B1), .sa_clr(clr1), .bit_valid(bv1), .busy(busy1), .done(done1)
    );

    sa_operand_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8),
        .A(A8), .B(B8), .sa_clr(clr8), .bit_valid(bv8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL reset_w4: got %b expected %b", o4, V_IDLE);
        end
        checks++;
        if (o1 !== V_IDLE) begin
            errors++;
            $display("FAIL reset_w1: got %b expected %b", o1, V_IDLE);
        end
        checks++;
        if (o8 !== V_IDLE) begin
            errors++;
            $display("FAIL reset_w8: got %b expected %b", o8, V_IDLE);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b", o4, V_IDLE);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [5:0] exp;
        ea = 4'b1011;
        eb = 4'b0110;
        a4 = ea; b4 = eb; st4 = 1'b1;
        tick();
        st4 = 1'b0;
        a4 = 4'b0000; b4 = 4'b1111;
        checks++;
        if (o4 !== V_CLEAR) begin
            errors++;
            $display("FAIL basic_clear: got %b expected %b", o4, V_CLEAR);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            exp = {ea[k], eb[k], 4'b0110};
            checks++;
            if (o4 !== exp) begin
                errors++;
                $display("FAIL basic_bit%0d: got %b expected %b", k, o4, exp);
            end
            tick();
        end
        checks++;
        if (o4 !== V_DONE) begin
            errors++;
            $display("FAIL basic_done: got %b expected %b", o4, V_DONE);
        end
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL basic_idle_after: got %b expected %b", o4, V_IDLE);
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [5:0] exp;
        ea = 4'b1011;
        eb = 4'b0110;
        a4 = ea; b4 = eb; st4 = 1'b1;
        tick();
        st4 = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp = {ea[k], eb[k], 4'b0110};
            checks++;
            if (o4 !== exp) begin
                errors++;
                $display("FAIL ignore_bit%0d: got %b expected %b", k, o4, exp);
            end
            if (k == 1) begin
                st4 = 1'b1; a4 = 4'b0000; b4 = 4'b1111;
            end else begin
                st4 = 1'b0;
            end
            tick();
        end
        checks++;
        if (o4 !== V_DONE) begin
            errors++;
            $display("FAIL ignore_done: got %b expected %b", o4, V_DONE);
        end
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL ignore_idle_after: got %b expected %b", o4, V_IDLE);
        end
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL ignore_no_retrigger: got %b expected %b", o4, V_IDLE);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [5:0] exp;
        a4 = 4'b1011; b4 = 4'b0110; st4 = 1'b1;
        tick();
        st4 = 1'b0;
        tick();
        tick();
        exp = {1'b1, 1'b1, 4'b0110};
        checks++;
        if (o4 !== exp) begin
            errors++;
            $display("FAIL rstmid_second_bit: got %b expected %b", o4, exp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (o4 !== V_IDLE) begin
                errors++;
                $display("FAIL rstmid_idle_c%0d: got %b expected %b", c, o4, V_IDLE);
            end
            tick();
        end
        // reset wins over a simultaneous start
        rst = 1'b1; st4 = 1'b1;
        tick();
        rst = 1'b0; st4 = 1'b0;
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL rst_priority: got %b expected %b", o4, V_IDLE);
        end
        tick();
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL rst_priority_late: got %b expected %b", o4, V_IDLE);
        end
        ea = 4'b0101;
        eb = 4'b1100;
        a4 = ea; b4 = eb; st4 = 1'b1;
        tick();
        st4 = 1'b0;
        checks++;
        if (o4 !== V_CLEAR) begin
            errors++;
            $display("FAIL rstmid_new_clear: got %b expected %b", o4, V_CLEAR);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            exp = {ea[k], eb[k], 4'b0110};
            checks++;
            if (o4 !== exp) begin
                errors++;
                $display("FAIL rstmid_new_bit%0d: got %b expected %b", k, o4, exp);
            end
            tick();
        end
        checks++;
        if (o4 !== V_DONE) begin
            errors++;
            $display("FAIL rstmid_new_done: got %b expected %b", o4, V_DONE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        int ph;
        a4 = 4'hF; b4 = 4'hF; st4 = 1'b1;
        tick();
        for (int c = 0; c < 21; c++) begin
            ph = c % 7;
            if (ph == 0)      exp = V_CLEAR;
            else if (ph <= 4) exp = 6'b110110;
            else if (ph == 5) exp = V_DONE;
            else              exp = V_IDLE;
            checks++;
            if (o4 !== exp) begin
                errors++;
                $display("FAIL b2b_c%0d: got %b expected %b", c, o4, exp);
            end
            if (c == 20) st4 = 1'b0;
            tick();
        end
        checks++;
        if (o4 !== V_IDLE) begin
            errors++;
            $display("FAIL b2b_stop: got %b expected %b", o4, V_IDLE);
        end
    endtask

    task automatic test_width1();
        a1 = 1'b1; b1 = 1'b0; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        checks++;
        if (o1 !== V_CLEAR) begin
            errors++;
            $display("FAIL w1_clear: got %b expected %b", o1, V_CLEAR);
        end
        tick();
        checks++;
        if (o1 !== 6'b100110) begin
            errors++;
            $display("FAIL w1_bit0: got %b expected %b", o1, 6'b100110);
        end
        tick();
        checks++;
        if (o1 !== V_DONE) begin
            errors++;
            $display("FAIL w1_done: got %b expected %b", o1, V_DONE);
        end
        tick();
        checks++;
        if (o1 !== V_IDLE) begin
            errors++;
            $display("FAIL w1_idle: got %b expected %b", o1, V_IDLE);
        end
    endtask

    task automatic test_serial_add();
        logic       carry;
        logic [7:0] f;
        carry = 1'bx;
        f = '0;
        a8 = 8'd200; b8 = 8'd100; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        checks++;
        if (o8 !== V_CLEAR) begin
            errors++;
            $display("FAIL add_clear: got %b expected %b", o8, V_CLEAR);
        end
        if (clr8 === 1'b1) carry = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (bv8 === 1'b1) begin
                f[k]  = A8 ^ B8 ^ carry;
                carry = (A8 & B8) | (A8 & carry) | (B8 & carry);
            end
            tick();
        end
        checks++;
        if (f !== 8'd44) begin
            errors++;
            $display("FAIL add_sum: got %0d expected %0d", f, 8'd44);
        end
        checks++;
        if (carry !== 1'b1) begin
            errors++;
            $display("FAIL add_cout: got %b expected %b", carry, 1'b1);
        end
        checks++;
        if (o8 !== V_DONE) begin
            errors++;
            $display("FAIL add_done: got %b expected %b", o8, V_DONE);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        st4 = 1'b0; st1 = 1'b0; st8 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_shift();
        test_back_to_back();
        test_width1();
        test_serial_add();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_operand_serializer.md
SA_OPERAND_SERIALIZER -- requirements
Module: sa_operand_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 1..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port start, input, 1, request to serialize the current a_in/b_in; honoured only in IDLE.
REQ-005 SHALL have port a_in, input, WIDTH, parallel operand A, captured on the accepting edge.
REQ-006 SHALL have port b_in, input, WIDTH, parallel operand B, captured on the accepting edge.
REQ-007 SHALL have port A, output, 1, serial operand A bit to the serial adder, LSB first.
REQ-008 SHALL have port B, output, 1, serial operand B bit to the serial adder, LSB first.
REQ-009 SHALL have port sa_clr, output, 1, high for one cycle to clear the downstream serial adder carry before bit 0.
REQ-010 SHALL have port bit_valid, output, 1, high on every cycle in which A/B carry an operand bit.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last bit.

Function
REQ-013 SHALL implement a 4-state FSM: IDLE, CLEAR, SHIFT, DONE.
REQ-014 IDLE: start=1 at an edge -> load a_in/b_in into internal shift registers, clear bit counter, go to CLEAR; start=0 -> stay IDLE.
REQ-015 CLEAR: lasts exactly one cycle; sa_clr=1, A=B=0, bit_valid=0; next edge -> SHIFT.
REQ-016 SHIFT: A=a_sh[0], B=b_sh[0], bit_valid=1; each edge shifts both registers right by one (zero fill) and increments counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the edge where counter equals WIDTH-1 -> DONE.
REQ-018 DONE: lasts one cycle; done=1, A=B=0, bit_valid=0; next edge -> IDLE unconditionally.
REQ-019 Latency: start accepted at edge E0 -> sa_clr in cycle after E0; bit k on cycle E0+2+k; done on cycle E0+WIDTH+2.
REQ-020 start SHALL be ignored in CLEAR, SHIFT, DONE; a_in/b_in changes after acceptance SHALL not affect output bits.
REQ-021 start held continuously SHALL yield back-to-back transactions separated by exactly one IDLE cycle.
REQ-022 Counter width SHALL be ceil(log2(WIDTH))+1 bits so WIDTH=32 does not wrap; WIDTH=1 -> single SHIFT cycle.
REQ-023 All outputs SHALL be decoded from registered state/data only; no combinational path from start, a_in, b_in to any output.
REQ-024 In IDLE: A=B=0, sa_clr=0, bit_valid=0, busy=0, done=0.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, clear shift registers and counter, from any state including mid-SHIFT.
REQ-026 rst SHALL take priority over start at the same edge; the transaction is not accepted.
REQ-027 After reset, all outputs = 0 until the next accepted start.

Verification
REQ-028 WIDTH=4, a_in=4'b1011, b_in=4'b0110, start one cycle -> sa_clr one cycle, then A=1,1,0,1 and B=0,1,1,0 with bit_valid=1 for 4 cycles, then done=1 one cycle, busy=0 after.
REQ-029 WIDTH=4, start pulsed again during SHIFT with different operands -> ignored; output bit stream and done timing unchanged from REQ-028.
REQ-030 WIDTH=4, rst=1 on 2nd SHIFT cycle -> next cycle all outputs 0, state IDLE, no done pulse; new start then runs full transaction.
REQ-031 WIDTH=4, start held high, a_in=4'hF, b_in=4'hF -> repeated transactions, period WIDTH+3=7 cycles, each emitting A=B=1 for 4 bits.
REQ-032 WIDTH=1, a_in=1, b_in=0 -> CLEAR, one SHIFT cycle with A=1,B=0, done on 3rd cycle after accepting edge.
REQ-033 Connect to serial adder (sa_clr to its rst), WIDTH=8, a_in=8'd200, b_in=8'd100 -> collected F bits = 8'd44, final Cout=1.
